// File: rtl/sensor_sched_pkg.sv
// Shared constants for the continuous-sensing poll scheduler: command codes,
// slot kinds, FSM state encoding and slot index width.
package sensor_sched_pkg;

    localparam int unsigned SLOT_W  = 6;
    localparam int unsigned N_SLOTS = 1 << SLOT_W;
    localparam int unsigned STATE_W = 2;

    localparam logic [7:0] CMD_START_T = 8'd4;
    localparam logic [7:0] CMD_START_H = 8'd5;
    localparam logic [7:0] CMD_STOP_T  = 8'd6;
    localparam logic [7:0] CMD_STOP_H  = 8'd7;

    localparam logic KIND_TEMP = 1'b0;
    localparam logic KIND_HUM  = 1'b1;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ    = 2'd1;
    localparam logic [STATE_W-1:0] ST_REPORT = 2'd2;
    localparam logic [STATE_W-1:0] ST_GAP    = 2'd3;

endpackage

// File: rtl/rr_slot_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant,
// wrapping modulo the slot count.
module rr_slot_arbiter
    import sensor_sched_pkg::*;
(
    input  logic [N_SLOTS-1:0] request,
    input  logic [SLOT_W-1:0]  last_grant,
    output logic               grant_valid,
    output logic [SLOT_W-1:0]  grant_index
);

    always_comb begin
        logic [SLOT_W-1:0] idx;
        grant_valid = 1'b0;
        grant_index = '0;
        idx         = '0;
        // Offset 64 wraps back onto last_grant itself, so it is searched last.
        for (int i = 1; i <= N_SLOTS; i++) begin
            idx = last_grant + SLOT_W'(i);
            if (!grant_valid && request[idx]) begin
                grant_valid = 1'b1;
                grant_index = idx;
            end
        end
    end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Round-robin scheduler sharing one sensor datapath across (address, kind)
// slots, with timeout, report handshake and minimum inter-access gap.
module sensor_poll_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int unsigned N_ADDR         = 32,
    parameter int unsigned MIN_GAP_CYCLES = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_code,
    input  logic [7:0]  cmd_address,
    output logic        cmd_reject,
    output logic        sensor_req,
    output logic [4:0]  sensor_address,
    output logic        sensor_kind,
    input  logic        sensor_done,
    input  logic        sensor_error,
    output logic        report_valid,
    output logic [4:0]  report_address,
    output logic        report_kind,
    output logic        report_error,
    input  logic        report_ready,
    output logic [31:0] active_temp,
    output logic [31:0] active_hum,
    output logic        busy
);

    localparam int unsigned CNT_MAX = (MIN_GAP_CYCLES > TIMEOUT_CYCLES) ? MIN_GAP_CYCLES
                                                                        : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [SLOT_W-1:0]  last_grant;
    logic [SLOT_W-1:0]  last_grant_next;

    logic               req_next;
    logic [4:0]         addr_next;
    logic               kind_next;
    logic               rep_valid_next;
    logic [4:0]         rep_addr_next;
    logic               rep_kind_next;
    logic               rep_err_next;

    logic [N_SLOTS-1:0] request;
    logic               grant_valid;
    logic [SLOT_W-1:0]  grant_index;

    logic               cmd_ok;
    logic               cmd_set;
    logic               cmd_kind;

    // Command decode: start/stop of one kind, address range checked.
    always_comb begin
        cmd_ok   = 1'b0;
        cmd_set  = 1'b0;
        cmd_kind = KIND_TEMP;
        case (cmd_code)
            CMD_START_T: begin cmd_ok = 1'b1; cmd_set = 1'b1; cmd_kind = KIND_TEMP; end
            CMD_START_H: begin cmd_ok = 1'b1; cmd_set = 1'b1; cmd_kind = KIND_HUM;  end
            CMD_STOP_T:  begin cmd_ok = 1'b1; cmd_set = 1'b0; cmd_kind = KIND_TEMP; end
            CMD_STOP_H:  begin cmd_ok = 1'b1; cmd_set = 1'b0; cmd_kind = KIND_HUM;  end
            default:     ;
        endcase
        if (32'(cmd_address) >= N_ADDR) begin
            cmd_ok = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            active_temp <= '0;
            active_hum  <= '0;
            cmd_reject  <= 1'b0;
        end else begin
            cmd_reject <= cmd_valid & ~cmd_ok;
            if (cmd_valid && cmd_ok) begin
                if (cmd_kind == KIND_HUM) begin
                    active_hum[cmd_address[4:0]] <= cmd_set;
                end else begin
                    active_temp[cmd_address[4:0]] <= cmd_set;
                end
            end
        end
    end

    // Slot s = {address, kind}: even bits temperature, odd bits humidity.
    always_comb begin
        request = '0;
        for (int a = 0; a < 32; a++) begin
            request[2*a]     = active_temp[a];
            request[2*a + 1] = active_hum[a];
        end
    end

    rr_slot_arbiter u_arbiter (
        .request     (request),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= SLOT_W'(N_SLOTS - 1);
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_grant <= last_grant_next;
        end
    end

    // One counter serves both the REQ timeout and the GAP wait.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_grant_next = last_grant;
        req_next        = 1'b0;
        addr_next       = sensor_address;
        kind_next       = sensor_kind;
        rep_valid_next  = 1'b0;
        rep_addr_next   = report_address;
        rep_kind_next   = report_kind;
        rep_err_next    = report_error;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next      = ST_REQ;
                    cnt_next        = '0;
                    req_next        = 1'b1;
                    last_grant_next = grant_index;
                    addr_next       = grant_index[SLOT_W-1:1];
                    kind_next       = grant_index[0];
                end
            end
            ST_REQ: begin
                if (sensor_done || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next     = ST_REPORT;
                    cnt_next       = '0;
                    rep_valid_next = 1'b1;
                    rep_addr_next  = sensor_address;
                    rep_kind_next  = sensor_kind;
                    rep_err_next   = sensor_done ? sensor_error : 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                    req_next = 1'b1;
                end
            end
            ST_REPORT: begin
                if (report_ready) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end else begin
                    rep_valid_next = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == CNT_W'(MIN_GAP_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sensor_req     <= 1'b0;
            sensor_address <= '0;
            sensor_kind    <= 1'b0;
            report_valid   <= 1'b0;
            report_address <= '0;
            report_kind    <= 1'b0;
            report_error   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            sensor_req     <= req_next;
            sensor_address <= addr_next;
            sensor_kind    <= kind_next;
            report_valid   <= rep_valid_next;
            report_address <= rep_addr_next;
            report_kind    <= rep_kind_next;
            report_error   <= rep_err_next;
            busy           <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Self-checking bench for sensor_poll_scheduler: command table, directed
// multi-cycle sequences and randomized traffic against a slot-level model.
module tb_sensor_poll_scheduler;

    localparam int unsigned N_ADDR  = 32;
    localparam int unsigned MIN_GAP = 10;
    localparam int unsigned TIMEOUT = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_address;
    logic        cmd_reject;
    logic        sensor_req;
    logic [4:0]  sensor_address;
    logic        sensor_kind;
    logic        sensor_done;
    logic        sensor_error;
    logic        report_valid;
    logic [4:0]  report_address;
    logic        report_kind;
    logic        report_error;
    logic        report_ready;
    logic [31:0] active_temp;
    logic [31:0] active_hum;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    sensor_poll_scheduler #(
        .N_ADDR         (N_ADDR),
        .MIN_GAP_CYCLES (MIN_GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .cmd_address    (cmd_address),
        .cmd_reject     (cmd_reject),
        .sensor_req     (sensor_req),
        .sensor_address (sensor_address),
        .sensor_kind    (sensor_kind),
        .sensor_done    (sensor_done),
        .sensor_error   (sensor_error),
        .report_valid   (report_valid),
        .report_address (report_address),
        .report_kind    (report_kind),
        .report_error   (report_error),
        .report_ready   (report_ready),
        .active_temp    (active_temp),
        .active_hum     (active_hum),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_code     = 8'd0;
        cmd_address  = 8'd0;
        sensor_done  = 1'b0;
        sensor_error = 1'b0;
        report_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] code, input logic [7:0] addr);
        cmd_valid   = 1'b1;
        cmd_code    = code;
        cmd_address = addr;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic pulse_done(input logic err);
        sensor_done  = 1'b1;
        sensor_error = err;
        tick();
        sensor_done  = 1'b0;
        sensor_error = 1'b0;
    endtask

    task automatic wait_req(input int limit, output int slot);
        slot = -1;
        for (int i = 0; i < limit; i++) begin
            if (sensor_req) begin
                slot = int'({sensor_address, sensor_kind});
                break;
            end
            tick();
        end
        n_checks++;
        if (slot < 0) begin
            n_errors++;
            $display("FAIL wait_req: got no sensor_req expected one within %0d cycles", limit);
        end
    endtask

    // Slot-level reference: phase, countdowns and per-address activity arrays.
    localparam int P_IDLE = 0, P_REQ = 1, P_REPORT = 2, P_GAP = 3;
    int       m_phase, m_age, m_gap, m_last;
    bit [4:0] m_addr, m_raddr;
    bit       m_kind, m_rkind, m_rerr, m_rej;
    bit       m_t[32];
    bit       m_h[32];

    task automatic m_reset();
        m_phase = P_IDLE; m_age = 0; m_gap = 0; m_last = 63;
        m_addr = 0; m_kind = 0; m_raddr = 0; m_rkind = 0; m_rerr = 0; m_rej = 0;
        for (int a = 0; a < 32; a++) begin
            m_t[a] = 0;
            m_h[a] = 0;
        end
    endtask

    function automatic int m_find();
        for (int k = 1; k <= 64; k++) begin
            int s = (m_last + k) % 64;
            if ((s % 2 == 0 && m_t[s/2]) || (s % 2 == 1 && m_h[s/2])) return s;
        end
        return -1;
    endfunction

    function automatic logic [31:0] m_vec(input bit hum);
        logic [31:0] v = '0;
        for (int a = 0; a < 32; a++) v[a] = hum ? m_h[a] : m_t[a];
        return v;
    endfunction

    // Advance the model across one clock edge using the inputs now driven.
    task automatic m_step();
        int s;
        if (reset) begin
            m_reset();
            return;
        end
        case (m_phase)
            P_IDLE: begin
                s = m_find();
                if (s >= 0) begin
                    m_phase = P_REQ; m_age = 0; m_last = s;
                    m_addr = 5'(s / 2); m_kind = 1'(s % 2);
                end
            end
            P_REQ: begin
                if (sensor_done) begin
                    m_phase = P_REPORT; m_raddr = m_addr; m_rkind = m_kind; m_rerr = sensor_error;
                end else if (m_age == int'(TIMEOUT) - 1) begin
                    m_phase = P_REPORT; m_raddr = m_addr; m_rkind = m_kind; m_rerr = 1;
                end else begin
                    m_age++;
                end
            end
            P_REPORT: if (report_ready) begin m_phase = P_GAP; m_gap = int'(MIN_GAP); end
            default: begin
                m_gap--;
                if (m_gap == 0) m_phase = P_IDLE;
            end
        endcase
        m_rej = 0;
        if (cmd_valid) begin
            if (cmd_code >= 8'd4 && cmd_code <= 8'd7 && int'(cmd_address) < int'(N_ADDR)) begin
                if (cmd_code[0]) m_h[cmd_address[4:0]] = (cmd_code < 8'd6);
                else             m_t[cmd_address[4:0]] = (cmd_code < 8'd6);
            end else begin
                m_rej = 1;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  code;
        logic [7:0]  addr;
        logic        rej;
        logic [31:0] temp;
        logic [31:0] hum;
    } vec_t;

    vec_t vecs[12];
    int   exp_order[4];

    initial begin
        int slot, k, highs;

        vecs[0]  = '{8'd4, 8'd3,  1'b0, 32'h0000_0008, 32'h0000_0000};
        vecs[1]  = '{8'd5, 8'd3,  1'b0, 32'h0000_0008, 32'h0000_0008};
        vecs[2]  = '{8'd4, 8'd3,  1'b0, 32'h0000_0008, 32'h0000_0008};
        vecs[3]  = '{8'd9, 8'd3,  1'b1, 32'h0000_0008, 32'h0000_0008};
        vecs[4]  = '{8'd4, 8'd40, 1'b1, 32'h0000_0008, 32'h0000_0008};
        vecs[5]  = '{8'd4, 8'd31, 1'b0, 32'h8000_0008, 32'h0000_0008};
        vecs[6]  = '{8'd6, 8'd3,  1'b0, 32'h8000_0000, 32'h0000_0008};
        vecs[7]  = '{8'd7, 8'd3,  1'b0, 32'h8000_0000, 32'h0000_0000};
        vecs[8]  = '{8'd3, 8'd0,  1'b1, 32'h8000_0000, 32'h0000_0000};
        vecs[9]  = '{8'd5, 8'd32, 1'b1, 32'h8000_0000, 32'h0000_0000};
        vecs[10] = '{8'd7, 8'd31, 1'b0, 32'h8000_0000, 32'h0000_0000};
        vecs[11] = '{8'd6, 8'd31, 1'b0, 32'h0000_0000, 32'h0000_0000};
        exp_order = '{6, 7, 62, 6};

        // Reset values
        do_reset();
        check("rst_req",   64'(sensor_req), 64'(0));
        check("rst_valid", 64'(report_valid), 64'(0));
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_rej",   64'(cmd_reject), 64'(0));
        check("rst_masks", 64'({active_temp, active_hum}), 64'(0));
        check("rst_fields", 64'({sensor_address, sensor_kind, report_address, report_kind, report_error}), 64'(0));

        // Command table: masks and reject pulse
        for (int i = 0; i < 12; i++) begin
            send_cmd(vecs[i].code, vecs[i].addr);
            check($sformatf("tbl%0d_rej", i),  64'(cmd_reject), 64'(vecs[i].rej));
            check($sformatf("tbl%0d_temp", i), 64'(active_temp), 64'(vecs[i].temp));
            check($sformatf("tbl%0d_hum", i),  64'(active_hum), 64'(vecs[i].hum));
            tick();
            check($sformatf("tbl%0d_rej_clr", i), 64'(cmd_reject), 64'(0));
        end

        // Single transaction, grant latency and gap length
        do_reset();
        send_cmd(8'd4, 8'd3);
        check("a_temp", 64'(active_temp), 64'h8);
        check("a_req_early", 64'(sensor_req), 64'(0));
        tick();
        check("a_req", 64'(sensor_req), 64'(1));
        check("a_slot", 64'({sensor_address, sensor_kind}), 64'(6));
        repeat (4) tick();
        pulse_done(1'b0);
        check("a_req_drop", 64'(sensor_req), 64'(0));
        check("a_report", 64'({report_valid, report_address, report_kind, report_error}), 64'({1'b1, 5'd3, 1'b0, 1'b0}));
        k = 0;
        while (!sensor_req && k < 40) begin
            tick();
            k++;
        end
        check("a_gap_len", 64'(k), 64'(12));

        // Round-robin order with wrap
        do_reset();
        send_cmd(8'd4, 8'd3);
        send_cmd(8'd5, 8'd3);
        send_cmd(8'd4, 8'd31);
        for (int j = 0; j < 4; j++) begin
            wait_req(60, slot);
            check($sformatf("b_order%0d", j), 64'(slot), 64'(exp_order[j]));
            pulse_done(1'b0);
        end

        // Stop of the in-flight slot
        do_reset();
        send_cmd(8'd4, 8'd3);
        wait_req(5, slot);
        send_cmd(8'd6, 8'd3);
        check("c_temp_clr", 64'(active_temp), 64'(0));
        check("c_still_req", 64'(sensor_req), 64'(1));
        pulse_done(1'b0);
        check("c_report", 64'({report_valid, report_address, report_kind, report_error}), 64'({1'b1, 5'd3, 1'b0, 1'b0}));
        highs = 0;
        repeat (40) begin
            tick();
            if (sensor_req) highs++;
        end
        check("c_no_regrant", 64'(highs), 64'(0));
        check("c_busy_idle", 64'(busy), 64'(0));

        // Timeout
        do_reset();
        send_cmd(8'd5, 8'd5);
        wait_req(5, slot);
        check("d_slot", 64'(slot), 64'(11));
        k = 0;
        while (sensor_req && k < 100) begin
            tick();
            k++;
        end
        check("d_req_len", 64'(k), 64'(TIMEOUT));
        check("d_report", 64'({report_valid, report_address, report_kind, report_error}), 64'({1'b1, 5'd5, 1'b1, 1'b1}));

        // Reset mid-REQ
        do_reset();
        send_cmd(8'd4, 8'd7);
        wait_req(5, slot);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("e_outs", 64'({sensor_req, sensor_address, sensor_kind, report_valid, report_address,
                             report_kind, report_error, busy, cmd_reject}), 64'(0));
        check("e_masks", 64'({active_temp, active_hum}), 64'(0));
        pulse_done(1'b1);
        tick();
        check("e_no_report", 64'({report_valid, busy}), 64'(0));
        send_cmd(8'd4, 8'd0);
        wait_req(5, slot);
        check("e_first_slot", 64'(slot), 64'(0));

        // Report held while ready is low
        do_reset();
        send_cmd(8'd4, 8'd4);
        wait_req(5, slot);
        report_ready = 1'b0;
        pulse_done(1'b1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("f_hold%0d", i), 64'({report_valid, report_address, report_kind, report_error}),
                  64'({1'b1, 5'd4, 1'b0, 1'b1}));
            tick();
        end
        check("f_hold_last", 64'({report_valid, report_address, report_kind, report_error}), 64'({1'b1, 5'd4, 1'b0, 1'b1}));
        report_ready = 1'b1;
        tick();
        check("f_gap", 64'({report_valid, busy, sensor_req}), 64'({1'b0, 1'b1, 1'b0}));
        k = 1;
        while (!sensor_req && k < 60) begin
            tick();
            k++;
        end
        check("f_gap_len", 64'(k), 64'(12));

        // Randomized traffic against the model
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            check("rnd_ctl",
                  64'({sensor_req, sensor_address, sensor_kind, report_valid, report_address,
                       report_kind, report_error, busy, cmd_reject}),
                  64'({m_phase == P_REQ, m_addr, m_kind, m_phase == P_REPORT, m_raddr,
                       m_rkind, m_rerr, m_phase != P_IDLE, m_rej}));
            check("rnd_temp", 64'(active_temp), 64'(m_vec(1'b0)));
            check("rnd_hum",  64'(active_hum),  64'(m_vec(1'b1)));
            reset        = ($urandom_range(0, 499) == 0);
            cmd_valid    = ($urandom_range(0, 5) == 0);
            cmd_code     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(4, 7));
            cmd_address  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(28, 45)) : 8'($urandom_range(0, 5));
            sensor_done  = ($urandom_range(0, 5) == 0);
            sensor_error = 1'($urandom_range(0, 1));
            report_ready = ($urandom_range(0, 2) != 0);
            m_step();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
